// File: rtl/seq_mantissa_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_mantissa_mul
// Description : Iterative radix-2 shift-add unsigned multiplier producing the
//               2N-bit mantissa product for the FP multiply path. One
//               (N+1)-bit adder row, one multiplier bit consumed per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mantissa_mul #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     a_q, a_d;        // partial product high half, MSB holds the carry
  logic [N-1:0]   q_q, q_d;        // multiplier bits, shifted out LSB first
  logic [N-1:0]   m_q, m_d;        // captured multiplicand
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;
  logic [N:0]     sum;

  // Next-state, datapath step and output decode.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    sum       = a_q + (q_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // {A,Q} <= {sum,Q} >> 1 ; the vacated MSB of A is zero.
        a_d     = {1'b0, sum[N:1]};
        q_d     = {sum[0], q_q[N-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == C_LAST) begin
          // The last shift completes on this edge, so the product is taken
          // from the shifted value rather than the registered one.
          product_d = {sum, q_q[N-1:1]};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
`default_nettype wire
